// File: rtl/trap_sequencer.sv
// ----------------------------------------------------------------------------
// trap_sequencer: prioritises synchronous exceptions and MRET, sequences the
// mepc/mcause CSR writes, redirects the PC, and arbitrates the CSR write port.
// Optional trap-entry counter enabled by defining TRAP_SEQ_COUNT_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module trap_sequencer #(
   parameter int unsigned ROM_LIMIT = 100,
   parameter int unsigned RAM_LIMIT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr_i,
   input  logic [15:0] pc_i,
   input  logic [15:0] ram_addr_i,
   input  logic        mem_acc_i,
   input  logic        instr_v_i,
   input  logic [31:0] mtvec_i,
   input  logic [31:0] mepc_i,
   input  logic        dp_csr_w_i,
   input  logic [11:0] dp_csr_i,
   input  logic [31:0] dp_wd_i,
   output logic        dp_gnt_o,
   output logic        csr_w_o,
   output logic [11:0] csr_o,
   output logic [31:0] wd_o,
   output logic        stall_o,
   output logic [1:0]  op_m_o,
   output logic [31:0] addr_o,
   output logic [15:0] trap_cnt_o
);

   localparam logic [15:0] ROM_LIM = 16'(ROM_LIMIT);
   localparam logic [15:0] RAM_LIM = 16'(RAM_LIMIT);
   localparam logic [11:0] CSR_MEPC   = 12'h041;
   localparam logic [11:0] CSR_MCAUSE = 12'h042;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_SAVE_EPC   = 3'd1,
      S_SAVE_CAUSE = 3'd2,
      S_JUMP       = 3'd3,
      S_RET        = 3'd4
   } state_t;

   state_t      state, next_state;
   logic [31:0] epc_q;
   logic [2:0]  cause_q;
   logic [2:0]  cause;
   logic [6:0]  opcode;
   logic        fetch_fault, illegal, is_system, ebreak, mret, load_fault;
   logic        exc_det, mret_det;
   logic        unused_bits;

   assign opcode      = instr_i[6:0];
   assign fetch_fault = (pc_i > ROM_LIM);
   assign illegal     = !(opcode inside {7'd3, 7'd19, 7'd35, 7'd51, 7'd99, 7'd111, 7'd115});
   assign is_system   = (opcode == 7'd115) && (instr_i[14:12] == 3'b000);
   assign ebreak      = is_system && (instr_i[31:20] == 12'h001);
   assign mret        = is_system && (instr_i[31:20] == 12'h002);
   assign load_fault  = mem_acc_i && (ram_addr_i > RAM_LIM);
   assign exc_det     = instr_v_i && (fetch_fault || illegal || ebreak || load_fault);
   assign mret_det    = instr_v_i && mret;
   assign unused_bits = ^{instr_i[19:15], instr_i[11:7]};

   always_comb begin
      cause = 3'd4;
      if (fetch_fault)  cause = 3'd0;
      else if (illegal) cause = 3'd2;
      else if (ebreak)  cause = 3'd3;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         epc_q   <= '0;
         cause_q <= '0;
      end else begin
         state <= next_state;
         if (state == S_IDLE && exc_det) begin
            epc_q   <= {16'b0, pc_i};
            cause_q <= cause;
         end
      end
   end

   always_comb begin
      next_state = state;
      dp_gnt_o   = 1'b0;
      csr_w_o    = 1'b0;
      csr_o      = '0;
      wd_o       = '0;
      stall_o    = 1'b0;
      op_m_o     = 2'b00;
      addr_o     = '0;
      unique case (state)
         S_IDLE: begin
            if (exc_det) begin
               next_state = S_SAVE_EPC;
               stall_o    = 1'b1;
            end else begin
               if (mret_det) next_state = S_RET;
               if (dp_csr_w_i) begin
                  dp_gnt_o = 1'b1;
                  csr_w_o  = 1'b1;
                  csr_o    = dp_csr_i;
                  wd_o     = dp_wd_i;
               end
            end
         end
         S_SAVE_EPC: begin
            next_state = S_SAVE_CAUSE;
            csr_w_o    = 1'b1;
            csr_o      = CSR_MEPC;
            wd_o       = epc_q;
            stall_o    = 1'b1;
         end
         S_SAVE_CAUSE: begin
            next_state = S_JUMP;
            csr_w_o    = 1'b1;
            csr_o      = CSR_MCAUSE;
            wd_o       = {29'b0, cause_q};
            stall_o    = 1'b1;
         end
         S_JUMP: begin
            next_state = S_IDLE;
            op_m_o     = 2'b11;
            addr_o     = mtvec_i;
            stall_o    = 1'b1;
         end
         S_RET: begin
            next_state = S_IDLE;
            op_m_o     = 2'b11;
            addr_o     = mepc_i;
         end
         default: next_state = S_IDLE;
      endcase
      // Outputs are held quiet while reset is asserted so no in-flight CSR write escapes.
      if (rst) begin
         next_state = S_IDLE;
         dp_gnt_o   = 1'b0;
         csr_w_o    = 1'b0;
         csr_o      = '0;
         wd_o       = '0;
         stall_o    = 1'b0;
         op_m_o     = 2'b00;
         addr_o     = '0;
      end
   end

`ifdef TRAP_SEQ_COUNT_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (state == S_IDLE && exc_det && cnt_q != 16'hFFFF) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign trap_cnt_o = rst ? 16'd0 : cnt_q;
`else
   assign trap_cnt_o = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_trap_sequencer.sv
// ----------------------------------------------------------------------------
// tb_trap_sequencer: directed plus randomized stimulus against a cycle-plan
// reference model; expected outputs are queued and checked by a monitor.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_trap_sequencer;

   localparam int unsigned ROM_LIM = 100;
   localparam int unsigned RAM_LIM = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr_i;
   logic [15:0] pc_i, ram_addr_i;
   logic        mem_acc_i, instr_v_i;
   logic [31:0] mtvec_i, mepc_i;
   logic        dp_csr_w_i;
   logic [11:0] dp_csr_i;
   logic [31:0] dp_wd_i;
   logic        dp_gnt_o, csr_w_o, stall_o;
   logic [11:0] csr_o;
   logic [31:0] wd_o, addr_o;
   logic [1:0]  op_m_o;
   logic [15:0] trap_cnt_o;

   trap_sequencer #(.ROM_LIMIT(ROM_LIM), .RAM_LIMIT(RAM_LIM)) dut (
      .clk(clk), .rst(rst), .instr_i(instr_i), .pc_i(pc_i), .ram_addr_i(ram_addr_i),
      .mem_acc_i(mem_acc_i), .instr_v_i(instr_v_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
      .dp_csr_w_i(dp_csr_w_i), .dp_csr_i(dp_csr_i), .dp_wd_i(dp_wd_i), .dp_gnt_o(dp_gnt_o),
      .csr_w_o(csr_w_o), .csr_o(csr_o), .wd_o(wd_o), .stall_o(stall_o), .op_m_o(op_m_o),
      .addr_o(addr_o), .trap_cnt_o(trap_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        gnt;
      logic        w;
      logic [11:0] csr;
      logic [31:0] wd;
      logic        stall;
      logic [1:0]  opm;
      logic [31:0] addr;
      logic [15:0] cnt;
   } out_t;

   // One entry per future cycle already committed by an accepted trap or MRET.
   typedef struct {
      bit          w;
      logic [11:0] a;
      logic [31:0] d;
      bit          stall;
      bit          to_mtvec;
      bit          to_mepc;
   } plan_t;

   out_t  exp_q[$];
   plan_t plan[$];
   int    model_cnt = 0;
   int    tests = 0;
   int    fails = 0;
   bit    started = 1'b0;

   function automatic int cause_of(logic [31:0] ins, logic [15:0] pc, logic [15:0] ra, logic ma);
      logic [6:0] op;
      bit sys;
      op  = ins[6:0];
      sys = (op == 7'd115) && (ins[14:12] == 3'b000);
      if (pc > ROM_LIM) return 0;
      if (!(op inside {7'd3, 7'd19, 7'd35, 7'd51, 7'd99, 7'd111, 7'd115})) return 2;
      if (sys && ins[31:20] == 12'h001) return 3;
      if (ma && ra > RAM_LIM) return 4;
      return -1;
   endfunction

   function automatic bit is_mret(logic [31:0] ins);
      return ins[6:0] == 7'd115 && ins[14:12] == 3'b000 && ins[31:20] == 12'h002;
   endfunction

   function automatic logic [15:0] cnt_exp();
`ifdef TRAP_SEQ_COUNT_EN
      return 16'(model_cnt);
`else
      return 16'd0;
`endif
   endfunction

   task automatic apply(input logic r, input logic [31:0] ins, input logic v,
                        input logic [15:0] pc, input logic [15:0] ra, input logic ma,
                        input logic dw, input logic [11:0] dc, input logic [31:0] dd,
                        input logic [31:0] tv, input logic [31:0] ep);
      out_t  e;
      plan_t p;
      int    c;
      @(posedge clk);
      #1;
      rst = r; instr_i = ins; instr_v_i = v; pc_i = pc; ram_addr_i = ra; mem_acc_i = ma;
      dp_csr_w_i = dw; dp_csr_i = dc; dp_wd_i = dd; mtvec_i = tv; mepc_i = ep;
      e = '0;
      if (r) begin
         plan.delete();
         model_cnt = 0;
      end else if (plan.size() > 0) begin
         p       = plan.pop_front();
         e.w     = p.w;
         e.csr   = p.a;
         e.wd    = p.d;
         e.stall = p.stall;
         if (p.to_mtvec) begin e.opm = 2'b11; e.addr = tv; end
         if (p.to_mepc)  begin e.opm = 2'b11; e.addr = ep; end
         e.cnt = cnt_exp();
      end else begin
         e.cnt = cnt_exp();
         c = v ? cause_of(ins, pc, ra, ma) : -1;
         if (c >= 0) begin
            e.stall = 1'b1;
            plan.push_back('{1'b1, 12'h041, {16'b0, pc}, 1'b1, 1'b0, 1'b0});
            plan.push_back('{1'b1, 12'h042, 32'(c), 1'b1, 1'b0, 1'b0});
            plan.push_back('{1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 1'b0});
            if (model_cnt < 65535) model_cnt++;
         end else begin
            if (dw) begin e.gnt = 1'b1; e.w = 1'b1; e.csr = dc; e.wd = dd; end
            if (v && is_mret(ins)) plan.push_back('{1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b1});
         end
      end
      exp_q.push_back(e);
      started = 1'b1;
   endtask

   task automatic idle(input logic [31:0] tv, input logic [31:0] ep);
      apply(1'b0, 32'h00000013, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 12'h0, 32'h0, tv, ep);
   endtask

   always @(negedge clk) begin
      out_t a, e;
      if (started) begin
         a = {dp_gnt_o, csr_w_o, csr_o, wd_o, stall_o, op_m_o, addr_o, trap_cnt_o};
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL queue_empty t=%0t: DUT output present with no expected entry", $time);
         end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
               fails++;
               $display("FAIL outputs t=%0t got gnt=%b w=%b csr=%h wd=%h stall=%b opm=%b addr=%h cnt=%h required gnt=%b w=%b csr=%h wd=%h stall=%b opm=%b addr=%h cnt=%h",
                        $time, a.gnt, a.w, a.csr, a.wd, a.stall, a.opm, a.addr, a.cnt,
                        e.gnt, e.w, e.csr, e.wd, e.stall, e.opm, e.addr, e.cnt);
            end
         end
      end
   end

   initial begin
      logic [6:0]  legal_ops [7];
      logic [31:0] ins;
      int          k;
      legal_ops = '{7'd3, 7'd19, 7'd35, 7'd51, 7'd99, 7'd111, 7'd115};
      rst = 1'b1; instr_i = '0; instr_v_i = 1'b0; pc_i = '0; ram_addr_i = '0; mem_acc_i = 1'b0;
      dp_csr_w_i = 1'b0; dp_csr_i = '0; dp_wd_i = '0; mtvec_i = '0; mepc_i = '0;

      // Reset, including a valid exception and datapath write presented under reset.
      apply(1'b1, 32'h0000007F, 1'b1, 16'h0010, 16'h0, 1'b0, 1'b1, 12'h005, 32'h30, 32'h20, 32'h0);
      apply(1'b1, 32'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0);
      idle(32'h20, 32'h0);

      // Illegal opcode trap.
      apply(1'b0, 32'h0000007F, 1'b1, 16'h0010, 16'h0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h20, 32'h0);
      repeat (3) idle(32'h20, 32'h0);

      // Priority: fetch fault beats illegal opcode and load fault; extra valid cycles are ignored.
      apply(1'b0, 32'h0000007F, 1'b1, 16'd101, 16'd70, 1'b1, 1'b0, 12'h0, 32'h0, 32'h44, 32'h0);
      repeat (3) apply(1'b0, 32'h0000007F, 1'b1, 16'd101, 16'd70, 1'b1, 1'b1, 12'h5, 32'h1, 32'h44, 32'h0);
      idle(32'h44, 32'h0);

      // MRET with no stall and no CSR write.
      apply(1'b0, 32'h00200073, 1'b1, 16'h0020, 16'h0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 32'h10);
      idle(32'h0, 32'h10);

      // Arbitration: pass-through, then drop alongside EBREAK.
      apply(1'b0, 32'h00000013, 1'b1, 16'h0004, 16'h0, 1'b0, 1'b1, 12'h005, 32'h30, 32'h0, 32'h0);
      apply(1'b0, 32'h00100073, 1'b1, 16'h0008, 16'h0, 1'b0, 1'b1, 12'h005, 32'h30, 32'h80, 32'h0);
      repeat (3) idle(32'h80, 32'h0);

      // Load-address fault at the RAM limit boundary (64 legal, 65 faults), back-to-back.
      apply(1'b0, 32'h00000003, 1'b1, 16'd100, 16'd64, 1'b1, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0);
      apply(1'b0, 32'h00000003, 1'b1, 16'd100, 16'd65, 1'b1, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0);
      repeat (3) idle(32'h90, 32'h0);
      apply(1'b0, 32'h00000003, 1'b1, 16'd12, 16'd66, 1'b1, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0);
      repeat (3) idle(32'h94, 32'h0);

      // Reset while in SAVE_CAUSE, then a fresh exception.
      apply(1'b0, 32'h0000007F, 1'b1, 16'h0030, 16'h0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h20, 32'h0);
      idle(32'h20, 32'h0);
      apply(1'b1, 32'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h20, 32'h0);
      idle(32'h20, 32'h0);
      apply(1'b0, 32'h00100073, 1'b1, 16'h0034, 16'h0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h24, 32'h0);
      repeat (3) idle(32'h24, 32'h0);

      // Three traps plus one MRET for the trap counter.
      for (int t = 0; t < 3; t++) begin
         apply(1'b0, 32'h0000007F, 1'b1, 16'(t), 16'h0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h60, 32'h0);
         repeat (3) idle(32'h60, 32'h0);
      end
      apply(1'b0, 32'h00200073, 1'b1, 16'h0040, 16'h0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 32'h70);
      repeat (2) idle(32'h0, 32'h70);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         k = $urandom_range(0, 9);
         ins = $urandom();
         if (k <= 4)      ins = {ins[31:7], legal_ops[$urandom_range(0, 6)]};
         else if (k == 6) ins = 32'h00100073;
         else if (k == 7) ins = 32'h00200073;
         apply($urandom_range(0, 49) == 0, ins, $urandom_range(0, 4) != 0,
               16'($urandom_range(90, 110)), 16'($urandom_range(55, 75)), 1'($urandom()),
               1'($urandom()), 12'($urandom()), $urandom(), $urandom(), $urandom());
      end

      @(negedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
